// File: rtl/baseball_solver_pkg.sv
// Shared constants, state encoding and candidate helpers for the number-baseball solver.
// Codes are four BCD nibbles, most significant digit in [15:12].
package baseball_solver_pkg;

    localparam int          DIGIT_W    = 4;
    localparam int          NUM_DIGITS = 4;
    localparam logic [15:0] FIRST_CAND = 16'h0123;
    localparam logic [15:0] LAST_CAND  = 16'h9876;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEARCH,
        ST_CHECK,
        ST_ASK,
        ST_WAIT,
        ST_RECORD,
        ST_DONE,
        ST_FAIL
    } state_t;

    // A candidate is usable only if every nibble is a decimal digit and no digit repeats.
    function automatic logic cand_valid(input logic [15:0] c);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (c[i*DIGIT_W +: DIGIT_W] > 4'd9) ok = 1'b0;
            for (int j = i + 1; j < NUM_DIGITS; j++) begin
                if (c[i*DIGIT_W +: DIGIT_W] == c[j*DIGIT_W +: DIGIT_W]) ok = 1'b0;
            end
        end
        return ok;
    endfunction

    function automatic logic [15:0] bcd_inc(input logic [15:0] c);
        logic [15:0] r;
        logic        carry;
        r     = c;
        carry = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (carry) begin
                if (r[k*DIGIT_W +: DIGIT_W] >= 4'd9) begin
                    r[k*DIGIT_W +: DIGIT_W] = 4'd0;
                end else begin
                    r[k*DIGIT_W +: DIGIT_W] = r[k*DIGIT_W +: DIGIT_W] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/baseball_solver_score.sv
// Combinational strike/ball scorer: strike counts equal digits in equal positions,
// ball counts digits of q found in a at a different position.
module baseball_solver_score
    import baseball_solver_pkg::*;
(
    input  logic [15:0] a,
    input  logic [15:0] q,
    output logic [2:0]  strike,
    output logic [2:0]  ball
);

    always_comb begin
        strike = 3'd0;
        ball   = 3'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            for (int j = 0; j < NUM_DIGITS; j++) begin
                if (a[i*DIGIT_W +: DIGIT_W] == q[j*DIGIT_W +: DIGIT_W]) begin
                    if (i == j) strike = strike + 3'd1;
                    else        ball   = ball + 3'd1;
                end
            end
        end
    end

endmodule

// File: rtl/baseball_solver.sv
// Number-baseball solver: asks the first ascending candidate consistent with every recorded
// reply until the grader reports all four strikes, the candidates run out, or the channel stalls.
module baseball_solver
    import baseball_solver_pkg::*;
#(
    parameter int MAX_GUESS = 16,
    parameter int TIMEOUT   = 200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [15:0] question,
    output logic        ask_valid,
    input  logic        reply_ready,
    input  logic        reply_valid,
    output logic        ask_ready,
    input  logic [2:0]  strike,
    input  logic [2:0]  ball,
    input  logic        correct,
    output logic        done,
    output logic        fail,
    output logic [15:0] solution,
    output logic [4:0]  guesses,
    output state_t      dbg_state
);

    localparam int N_W   = $clog2(MAX_GUESS + 1);
    localparam int IDX_W = (MAX_GUESS > 1) ? $clog2(MAX_GUESS) : 1;
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    state_t           state, state_next;
    logic [15:0]      cand;
    logic [N_W-1:0]   n;
    logic [IDX_W-1:0] idx;
    logic [TO_W-1:0]  idle_cnt;
    logic [2:0]       r_strike, r_ball;
    logic             r_correct;
    logic [15:0]      hist_g [MAX_GUESS];
    logic [2:0]       hist_s [MAX_GUESS];
    logic [2:0]       hist_b [MAX_GUESS];
    logic [2:0]       sc_strike, sc_ball;
    logic             ask_xfer, reply_xfer, timeout, last_entry;
    logic             new_game, inc_cand, push, win;

    baseball_solver_score u_score (
        .a      (cand),
        .q      (hist_g[idx]),
        .strike (sc_strike),
        .ball   (sc_ball)
    );

    // Handshake: a question moves when ask_valid & reply_ready, a reply when reply_valid & ask_ready;
    // both are sampled on the rising clock edge and the two valids are never raised together.
    assign ask_valid  = (state == ST_ASK);
    assign ask_ready  = (state == ST_WAIT);
    assign question   = ask_valid ? cand : 16'h0000;
    assign done       = (state == ST_DONE);
    assign fail       = (state == ST_FAIL);
    assign dbg_state  = state;
    assign ask_xfer   = ask_valid & reply_ready;
    assign reply_xfer = reply_valid & ask_ready;
    assign timeout    = (idle_cnt == TO_W'(TIMEOUT - 1));
    assign last_entry = ((N_W'(idx) + N_W'(1)) == n);

    always_comb begin
        state_next = state;
        new_game   = 1'b0;
        inc_cand   = 1'b0;
        push       = 1'b0;
        win        = 1'b0;
        case (state)
            ST_IDLE, ST_DONE, ST_FAIL: begin
                if (start) begin
                    new_game   = 1'b1;
                    state_next = ST_SEARCH;
                end
            end
            ST_SEARCH: begin
                if (cand_valid(cand)) state_next = ST_CHECK;
                else                  inc_cand   = 1'b1;
            end
            ST_CHECK: begin
                if (n == '0) begin
                    state_next = ST_ASK;
                end else if (sc_strike != hist_s[idx] || sc_ball != hist_b[idx]) begin
                    inc_cand   = 1'b1;
                    state_next = ST_SEARCH;
                end else if (last_entry) begin
                    state_next = ST_ASK;
                end
            end
            ST_ASK: begin
                if (ask_xfer)     state_next = ST_WAIT;
                else if (timeout) state_next = ST_FAIL;
            end
            ST_WAIT: begin
                if (reply_xfer)   state_next = ST_RECORD;
                else if (timeout) state_next = ST_FAIL;
            end
            ST_RECORD: begin
                if (r_correct || r_strike == 3'd4) begin
                    win        = 1'b1;
                    state_next = ST_DONE;
                end else if (n == N_W'(MAX_GUESS)) begin
                    state_next = ST_FAIL;
                end else begin
                    push       = 1'b1;
                    inc_cand   = 1'b1;
                    state_next = ST_SEARCH;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        // Stepping beyond the last legal code means no candidate is left.
        if (inc_cand && cand == LAST_CAND) state_next = ST_FAIL;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            cand      <= FIRST_CAND;
            n         <= '0;
            idx       <= '0;
            idle_cnt  <= '0;
            r_strike  <= 3'd0;
            r_ball    <= 3'd0;
            r_correct <= 1'b0;
            solution  <= 16'h0000;
            guesses   <= 5'd0;
        end else begin
            state <= state_next;
            if (new_game) begin
                cand     <= FIRST_CAND;
                n        <= '0;
                guesses  <= 5'd0;
                solution <= 16'h0000;
            end
            if (inc_cand) cand <= bcd_inc(cand);
            if (push)     n    <= n + N_W'(1);
            if (win)      solution <= cand;
            idx <= (state == ST_CHECK) ? idx + IDX_W'(1) : '0;
            // Any state change (entry, transfer, exit) restarts the stall counter.
            if (state_next != state)                    idle_cnt <= '0;
            else if (state == ST_ASK || state == ST_WAIT) idle_cnt <= idle_cnt + TO_W'(1);
            if (ask_xfer && guesses != 5'd31) guesses <= guesses + 5'd1;
            if (reply_xfer) begin
                r_strike  <= strike;
                r_ball    <= ball;
                r_correct <= correct;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            hist_g[n[IDX_W-1:0]] <= cand;
            hist_s[n[IDX_W-1:0]] <= r_strike;
            hist_b[n[IDX_W-1:0]] <= r_ball;
        end
    end

endmodule
